// File: rtl/eeprom_spi_xfer.sv
// Bit-serial SPI transaction engine for the serial EEPROM: shifts one frame of up to 32 bits
// MSB-first, captures the response after the mux/pad latency, then optionally waits for MCU ready.
module eeprom_spi_xfer #(
   parameter int RX_LATENCY     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        SClk,
   input  logic        nReset,
   input  logic        Start,
   input  logic [31:0] TxData,
   input  logic [5:0]  TxBits,
   input  logic        WaitReady,
   input  logic        SPIDi,
   input  logic        MCUReady,
   output logic        Busy,
   output logic        Done,
   output logic        Timeout,
   output logic [31:0] RxData,
   output logic        SPISel,
   output logic        SPIDo,
   output logic        SPIClkRunning
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DRN_W = (RX_LATENCY > 1) ? $clog2(RX_LATENCY) : 1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(RX_LATENCY - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   logic [2:0]            state_reg;
   logic [2:0]            state_next;
   logic [31:0]           shift_reg;
   logic [5:0]            bits_reg;
   logic [5:0]            bit_cnt_reg;
   logic [DRN_W-1:0]      drain_cnt_reg;
   logic [CNT_W-1:0]      to_cnt_reg;
   logic                  wait_en_reg;
   logic [31:0]           rx_reg;
   logic                  timeout_reg;
   logic [RX_LATENCY-1:0] rx_valid_reg;
   logic                  ready_meta_reg;
   logic                  ready_sync_reg;
   logic                  ready_prev_reg;

   logic [5:0]  n_clamped;
   logic [31:0] shift_load;
   logic        ready_fall;
   logic        timeout_hit;
   logic        start_ok;
   logic        rx_sample;

   assign n_clamped   = (TxBits > 6'd32) ? 6'd32 : TxBits;
   assign shift_load  = TxData << (6'd32 - n_clamped);
   assign ready_fall  = ready_prev_reg & ~ready_sync_reg;
   assign timeout_hit = !ready_fall && (to_cnt_reg == TO_LAST);
   assign start_ok    = (state_reg == ST_IDLE) && Start;
   // The shift strobe delayed by the round-trip latency marks cycles where SPIDi holds a response bit.
   assign rx_sample   = rx_valid_reg[RX_LATENCY-1];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (Start) state_next = ST_SETUP;
         ST_SETUP: state_next = (bits_reg != 6'd0) ? ST_SHIFT : ST_DRAIN;
         ST_SHIFT: if (bit_cnt_reg == bits_reg - 6'd1) state_next = ST_DRAIN;
         ST_DRAIN: if (drain_cnt_reg == DRN_LAST) state_next = wait_en_reg ? ST_WAIT : ST_DONE;
         ST_WAIT:  if (ready_fall || timeout_hit) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge SClk) begin
      if (!nReset) begin
         state_reg      <= ST_IDLE;
         shift_reg      <= '0;
         bits_reg       <= '0;
         bit_cnt_reg    <= '0;
         drain_cnt_reg  <= '0;
         to_cnt_reg     <= '0;
         wait_en_reg    <= 1'b0;
         rx_reg         <= '0;
         timeout_reg    <= 1'b0;
         rx_valid_reg   <= '0;
         ready_meta_reg <= 1'b1;
         ready_sync_reg <= 1'b1;
         ready_prev_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         ready_meta_reg <= MCUReady;
         ready_sync_reg <= ready_meta_reg;
         ready_prev_reg <= ready_sync_reg;
         rx_valid_reg   <= RX_LATENCY'({rx_valid_reg, (state_reg == ST_SHIFT)});

         if (start_ok)
            rx_reg <= '0;
         else if (rx_sample)
            rx_reg <= {rx_reg[30:0], SPIDi};

         case (state_reg)
            ST_IDLE: begin
               if (Start) begin
                  shift_reg     <= shift_load;
                  bits_reg      <= n_clamped;
                  wait_en_reg   <= WaitReady;
                  timeout_reg   <= 1'b0;
                  bit_cnt_reg   <= '0;
                  drain_cnt_reg <= '0;
                  to_cnt_reg    <= '0;
               end
            end
            ST_SHIFT: begin
               shift_reg   <= {shift_reg[30:0], 1'b0};
               bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
            ST_DRAIN: drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);
            ST_WAIT: begin
               // A ready edge in the terminal cycle takes priority over the timeout.
               if (timeout_hit)
                  timeout_reg <= 1'b1;
               else if (!ready_fall)
                  to_cnt_reg <= to_cnt_reg + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign Busy          = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) ||
                          (state_reg == ST_DRAIN) || (state_reg == ST_WAIT);
   assign Done          = (state_reg == ST_DONE);
   assign SPISel        = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) ||
                          (state_reg == ST_DRAIN);
   assign SPIClkRunning = (state_reg == ST_SHIFT);
   assign SPIDo         = (state_reg == ST_SHIFT) && shift_reg[31];
   assign RxData        = rx_reg;
   assign Timeout       = timeout_reg;

endmodule

// File: tb/tb_eeprom_spi_xfer.sv
// Self-checking bench for eeprom_spi_xfer: directed and random frames against a cycle-count
// reference model, with a behavioural SPI device that answers after the round-trip latency.
module tb_eeprom_spi_xfer;

   localparam int RXL = 2;
   localparam int TO  = 4096;

   logic        SClk = 1'b0;
   logic        nReset;
   logic        Start;
   logic [31:0] TxData;
   logic [5:0]  TxBits;
   logic        WaitReady;
   logic        SPIDi;
   logic        MCUReady;
   logic        Busy;
   logic        Done;
   logic        Timeout;
   logic [31:0] RxData;
   logic        SPISel;
   logic        SPIDo;
   logic        SPIClkRunning;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   eeprom_spi_xfer #(.RX_LATENCY(RXL), .TIMEOUT_CYCLES(TO)) dut (
      .SClk(SClk), .nReset(nReset), .Start(Start), .TxData(TxData), .TxBits(TxBits),
      .WaitReady(WaitReady), .SPIDi(SPIDi), .MCUReady(MCUReady), .Busy(Busy), .Done(Done),
      .Timeout(Timeout), .RxData(RxData), .SPISel(SPISel), .SPIDo(SPIDo),
      .SPIClkRunning(SPIClkRunning)
   );

   always #5 SClk = ~SClk;
   always @(posedge SClk) cyc <= cyc + 1;

   // Device model: records MOSI on every clocked cycle and returns its response bit RXL cycles later.
   logic [31:0]    dev_resp = '0;
   int             dev_n    = 0;
   int             dev_idx  = 0;
   bit             dq[$];
   logic [RXL-1:0] dly      = '0;

   always @(negedge SClk) begin
      logic nb;
      SPIDi = dly[RXL-1];
      if (!SPISel) dev_idx = 0;
      if (SPIClkRunning) begin
         dq.push_back(SPIDo);
         nb = (dev_idx < dev_n) ? dev_resp[dev_n-1-dev_idx] : 1'($urandom);
         dev_idx++;
      end else begin
         nb = 1'($urandom);
      end
      dly = RXL'({dly, nb});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One frame; rise_off/fall_off drive MCUReady relative to the first cycle after SPISel drops,
   // glitch_rel pulses a stray Start (with different data) that many cycles after acceptance.
   task automatic do_xfer(input logic [31:0] tx, input int bits, input logic wr,
                          input logic [31:0] resp, input int rise_off, input int fall_off,
                          input int glitch_rel, input string tag);
      int n, e0, ee, done_c, edge_c;
      logic exp_to;
      logic [31:0] mask, mosi;
      @(negedge SClk);
      n = (bits > 32) ? 32 : bits;
      TxData = tx; TxBits = 6'(bits); WaitReady = wr;
      dev_resp = resp; dev_n = n; dq.delete();
      Start = 1'b1;
      e0 = cyc + 1;
      ee = e0 + 1 + n + RXL;
      edge_c = (wr && fall_off >= 0) ? ee + fall_off + 2 : -1;
      if (!wr) begin
         done_c = ee; exp_to = 1'b0;
      end else if (edge_c >= ee && edge_c <= ee + TO) begin
         done_c = edge_c + 1; exp_to = 1'b0;
      end else begin
         done_c = ee + TO + 1; exp_to = 1'b1;
      end
      mask = (n == 0) ? 32'h0 : (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      forever begin
         @(negedge SClk);
         Start = 1'b0; TxData = tx;
         if (cyc == e0) begin
            chk({tag, " rx_clear"}, RxData, 32'h0);
            chk({tag, " to_clear"}, 32'(Timeout), 32'h0);
         end
         chk({tag, " busy"}, 32'(Busy), 32'(cyc < done_c));
         chk({tag, " sel"},  32'(SPISel), 32'(cyc < ee));
         chk({tag, " clk"},  32'(SPIClkRunning), 32'(cyc >= e0 + 1 && cyc <= e0 + n));
         chk({tag, " done"}, 32'(Done), 32'(cyc == done_c));
         if (cyc == done_c) begin
            mosi = '0;
            foreach (dq[i]) mosi = {mosi[30:0], dq[i]};
            chk({tag, " rxdata"},  RxData, resp & mask);
            chk({tag, " timeout"}, 32'(Timeout), 32'(exp_to));
            chk({tag, " nclk"},    32'(dq.size()), 32'(n));
            chk({tag, " mosi"},    mosi, tx & mask);
            $display("xfer %s: tx=%08h bits=%0d wr=%0d rx=%08h timeout=%0d done_cycles=%0d",
                     tag, tx, bits, wr, RxData, Timeout, done_c - e0 + 1);
         end
         if (cyc == done_c + 1) begin
            chk({tag, " to_hold"}, 32'(Timeout), 32'(exp_to));
            chk({tag, " rx_hold"}, RxData, resp & mask);
            break;
         end
         if (rise_off >= 0 && cyc == ee + rise_off) MCUReady = 1'b1;
         if (fall_off >= 0 && cyc == ee + fall_off) MCUReady = 1'b0;
         if (glitch_rel >= 0 && cyc == e0 + glitch_rel) begin
            Start = 1'b1; TxData = ~tx;
         end
      end
      MCUReady = 1'b1;
      repeat (2) @(negedge SClk);
   endtask

   initial begin
      int e0, bits, n, fall, gl;
      logic wr;
      nReset = 1'b0; Start = 1'b0; TxData = '0; TxBits = '0; WaitReady = 1'b0; MCUReady = 1'b1;
      repeat (3) @(negedge SClk);
      chk("rst busy", 32'(Busy), 32'h0);
      chk("rst done", 32'(Done), 32'h0);
      chk("rst sel",  32'(SPISel), 32'h0);
      chk("rst clk",  32'(SPIClkRunning), 32'h0);
      chk("rst do",   32'(SPIDo), 32'h0);
      chk("rst rx",   RxData, 32'h0);
      chk("rst to",   32'(Timeout), 32'h0);
      nReset = 1'b1;
      @(negedge SClk);

      do_xfer(32'h0000_0120, 16, 1'b1, 32'h0000_FFFF, -1, 10, -1, "erase");
      do_xfer(32'h0143_ABBA, 32, 1'b0, 32'hDEAD_BEEF, -1, -1, -1, "write");
      do_xfer($urandom, 8, 1'b1, $urandom, -1, -1, -1, "timeout");
      do_xfer($urandom, 0, 1'b0, $urandom, -1, -1, -1, "zero_bits");
      MCUReady = 1'b0;
      do_xfer($urandom, 8, 1'b1, $urandom, TO - 10, TO - 2, -1, "low_then_edge");
      do_xfer($urandom, 16, 1'b0, $urandom, -1, -1, 5, "start_in_shift");
      do_xfer($urandom, 12, 1'b0, $urandom, -1, -1, 1 + 12 + RXL, "start_in_done");
      do_xfer($urandom, 45, 1'b0, $urandom, -1, -1, -1, "clamp45");

      // Reset while bit 5 of 16 is on the wire.
      @(negedge SClk);
      TxData = $urandom; TxBits = 6'd16; WaitReady = 1'b0;
      dev_resp = $urandom; dev_n = 16; dq.delete();
      Start = 1'b1;
      e0 = cyc + 1;
      @(negedge SClk);
      Start = 1'b0;
      while (cyc < e0 + 5) @(negedge SClk);
      chk("midrst clk_before", 32'(SPIClkRunning), 32'h1);
      nReset = 1'b0;
      @(negedge SClk);
      chk("midrst sel",  32'(SPISel), 32'h0);
      chk("midrst clk",  32'(SPIClkRunning), 32'h0);
      chk("midrst busy", 32'(Busy), 32'h0);
      chk("midrst done", 32'(Done), 32'h0);
      chk("midrst rx",   RxData, 32'h0);
      $display("xfer midreset: reset applied at bit 5 of 16");
      nReset = 1'b1;
      @(negedge SClk);
      do_xfer(32'h0000_A5C3, 16, 1'b0, 32'h0000_3C5A, -1, -1, -1, "after_reset");

      for (int i = 0; i < 20; i++) begin
         bits = $urandom_range(0, 63);
         n    = (bits > 32) ? 32 : bits;
         wr   = ($urandom_range(0, 3) == 0);
         fall = wr ? int'($urandom_range(0, 40)) : -1;
         gl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n + RXL + 1)) : -1;
         do_xfer($urandom, bits, wr, $urandom, -1, fall, wr ? -1 : gl, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
